burst_rr_scheduler: RTL

- Shares one single-port resource, such as a shared bus or memory port, between BUS_WIDTH requesters.
- Uses round-robin arbitration; once a requester wins, it owns the resource for a bounded burst.
- Sits in front of the shared datapath. It sequences ownership with a one-hot grant, counts transfer beats, and forcibly reclaims the resource on burst limit, release or stall timeout.

---
 rtl/burst_rr_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/burst_rr_scheduler.sv
// Round-robin owner scheduler for a single shared resource: grants one requester
// at a time for a bounded burst and reclaims on burst limit, release, req drop or stall.
module burst_rr_scheduler #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_WIDTH-1:0]         req,
  input  logic                         beat,
  // 'release' is a reserved word, so the early-release input is named release_req
  input  logic                         release_req,
  output logic [BUS_WIDTH-1:0]         grant,
  output logic [$clog2(BUS_WIDTH)-1:0] grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned ID_W = $clog2(BUS_WIDTH);
  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t                state_q, state_d;
  logic [BUS_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [ID_W-1:0]       last_id_q, last_id_d;

  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand_id;
  int unsigned           cand;
  logic                  exit_burst;
  logic                  exit_idle;
  logic                  exit_any;

  // Search starts just after the previous owner so it is considered last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= BUS_WIDTH; i++) begin
      cand    = (32'(last_id_q) + i) % BUS_WIDTH;
      cand_id = ID_W'(cand);
      if (!win_found && req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    last_id_d     = last_id_q;

    exit_burst = beat && (beat_cnt_q == BC_W'(MAX_BURST - 1));
    exit_idle  = !beat && (idle_cnt_q == IC_W'(TIMEOUT - 1));
    exit_any   = release_req || exit_burst || !req[grant_id_q] || exit_idle;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[win_id]  = 1'b1;
          grant_id_d       = win_id;
          busy_d           = 1'b1;
          beat_cnt_d       = '0;
          idle_cnt_d       = '0;
        end
      end
      OWN: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IC_W'(1);
        end
        if (exit_any) begin
          state_d       = GAP;
          grant_d       = '0;
          busy_d        = 1'b0;
          last_id_d     = grant_id_q;
          timeout_err_d = exit_idle && !release_req;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      last_id_q     <= ID_W'(BUS_WIDTH - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      last_id_q     <= last_id_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
